// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-port arbiter slice.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // One queued MDU result; killed marks a result overwritten by a younger pipe write.
  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  killed;
  } wb_entry_t;

  // One-hot register mask for a destination index.
  function automatic logic [NUM_REGS-1:0] rdOnehot(input logic [REG_ADDR_W-1:0] rd);
    return NUM_REGS'(1) << rd;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO of MDU results with a per-entry destination-match kill port.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  wb_entry_t                    pushEntry_i,
  input  logic                         pop_i,
  input  logic                         kill_i,
  input  logic [REG_ADDR_W-1:0]        killRd_i,
  output wb_entry_t                    head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_entry_t [DEPTH-1:0]        entries_o,
  output logic      [DEPTH-1:0]        valid_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic      [DEPTH-1:0] valid_q;
  logic      [PTR_W-1:0] wrPtr_q;
  logic      [PTR_W-1:0] rdPtr_q;
  logic      [IDX_W-1:0] wrIdx;
  logic      [IDX_W-1:0] rdIdx;

  assign wrIdx     = wrPtr_q[IDX_W-1:0];
  assign rdIdx     = rdPtr_q[IDX_W-1:0];
  assign empty_o   = (wrPtr_q == rdPtr_q);
  assign full_o    = (wrPtr_q[PTR_W-1] != rdPtr_q[PTR_W-1]) &&
                     (wrPtr_q[IDX_W-1:0] == rdPtr_q[IDX_W-1:0]);
  assign head_o    = mem_q[rdIdx];
  assign entries_o = mem_q;
  assign valid_o   = valid_q;

  // Pointer/valid bookkeeping plus kill marking; a push never targets a live slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      valid_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrIdx]   <= pushEntry_i;
        valid_q[wrIdx] <= 1'b1;
        wrPtr_q        <= wrPtr_q + PTR_W'(1);
      end
      if (pop_i) begin
        valid_q[rdIdx] <= 1'b0;
        rdPtr_q        <= rdPtr_q + PTR_W'(1);
      end
      if (kill_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && (mem_q[i].rd == killRd_i)) begin
            mem_q[i].killed <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline writeback stage and
// buffered MDU results, with a starvation stall so buffered results always drain.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       pipe_data,
  input  logic [REG_ADDR_W-1:0] pipe_rd,
  input  logic                  pipe_write_enable,
  input  logic                  mdu_valid,
  input  logic [XLEN-1:0]       mdu_data,
  input  logic [REG_ADDR_W-1:0] mdu_rd,
  output logic                  mdu_ready,
  output logic                  stall_pipe,
  output logic [XLEN-1:0]       out_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_write_enable,
  output logic [NUM_REGS-1:0]   pending_rd_mask
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

  logic                  fifoFull;
  logic                  fifoEmpty;
  wb_entry_t             head;
  wb_entry_t             pushEntry;
  wb_entry_t [DEPTH-1:0] entries;
  logic      [DEPTH-1:0] entryValid;

  logic pipeLive;
  logic headLive;
  logic grantPipe;
  logic grantHead;
  logic popHead;
  logic pushAccept;

  logic [CNT_W-1:0] starveCnt_q;
  logic [CNT_W-1:0] starveCnt_d;
  logic             stallPipe_q;
  logic             stallPipe_d;

  // A pipe write to x0 or during a forced stall never competes for the port.
  assign mdu_ready  = reset && !fifoFull;
  assign pipeLive   = reset && pipe_write_enable && (pipe_rd != '0) && !stallPipe_q;
  assign headLive   = reset && !fifoEmpty && !head.killed;
  assign grantPipe  = pipeLive;
  assign grantHead  = !pipeLive && headLive;
  assign popHead    = grantHead || (reset && !fifoEmpty && head.killed);
  assign pushAccept = mdu_valid && mdu_ready && (mdu_rd != '0);
  assign stall_pipe = stallPipe_q;

  assign pushEntry.data   = mdu_data;
  assign pushEntry.rd     = mdu_rd;
  assign pushEntry.killed = grantPipe && (mdu_rd == pipe_rd);

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (pushAccept),
    .pushEntry_i (pushEntry),
    .pop_i       (popHead),
    .kill_i      (grantPipe),
    .killRd_i    (pipe_rd),
    .head_o      (head),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .entries_o   (entries),
    .valid_o     (entryValid)
  );

  // Register-file write mux: pipe passthrough has priority over the buffer head.
  always_comb begin
    out_write_enable = grantPipe || grantHead;
    out_data         = pipe_data;
    out_rd           = pipe_rd;
    if (grantHead) begin
      out_data = head.data;
      out_rd   = head.rd;
    end
  end

  // Count blocked cycles of a live head; hitting the limit schedules a one-cycle stall.
  always_comb begin
    starveCnt_d = starveCnt_q;
    stallPipe_d = 1'b0;
    if (!headLive || grantHead) begin
      starveCnt_d = '0;
    end else if ((starveCnt_q + CNT_W'(1)) == LIMIT_V) begin
      starveCnt_d = '0;
      stallPipe_d = 1'b1;
    end else begin
      starveCnt_d = starveCnt_q + CNT_W'(1);
    end
  end

  // Starvation state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starveCnt_q <= '0;
      stallPipe_q <= 1'b0;
    end else begin
      starveCnt_q <= starveCnt_d;
      stallPipe_q <= stallPipe_d;
    end
  end

  // Pending-destination mask from stored, non-killed entries only.
  always_comb begin
    pending_rd_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && !entries[i].killed) begin
        pending_rd_mask = pending_rd_mask | rdOnehot(entries[i].rd);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a write scoreboard.
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] pipe_data;
  logic [4:0]  pipe_rd;
  logic        pipe_write_enable;
  logic        mdu_valid;
  logic [31:0] mdu_data;
  logic [4:0]  mdu_rd;
  logic        mdu_ready;
  logic        stall_pipe;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_write_enable;
  logic [31:0] pending_rd_mask;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t pipeQ[$];
  wr_t mduQ[$];
  int  errors = 0;
  int  checks = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .pipe_data         (pipe_data),
    .pipe_rd           (pipe_rd),
    .pipe_write_enable (pipe_write_enable),
    .mdu_valid         (mdu_valid),
    .mdu_data          (mdu_data),
    .mdu_rd            (mdu_rd),
    .mdu_ready         (mdu_ready),
    .stall_pipe        (stall_pipe),
    .out_data          (out_data),
    .out_rd            (out_rd),
    .out_write_enable  (out_write_enable),
    .pending_rd_mask   (pending_rd_mask)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge; record an expected pipe write.
  task automatic applyStimulus(input logic rst, input logic pwe, input logic [4:0] prd,
                               input logic [31:0] pdata, input logic mv,
                               input logic [4:0] mrd, input logic [31:0] mdata,
                               input logic expectPipe);
    wr_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    pipe_write_enable = pwe;
    pipe_rd           = prd;
    pipe_data         = pdata;
    mdu_valid         = mv;
    mdu_rd            = mrd;
    mdu_data          = mdata;
    if (expectPipe) begin
      e.rd   = prd;
      e.data = pdata;
      pipeQ.push_back(e);
    end
  endtask

  // Settle, then match any register-file write against the scoreboard.
  task automatic checkOutput();
    wr_t e;
    #2;
    if (pipeQ.size() != 0) begin
      e = pipeQ.pop_front();
      chk("pipe_we", 32'(out_write_enable), 32'd1);
      chk("pipe_rd", 32'(out_rd), 32'(e.rd));
      chk("pipe_data", out_data, e.data);
    end else if (out_write_enable) begin
      chk("mdu_write_expected", 32'(mduQ.size() != 0), 32'd1);
      if (mduQ.size() != 0) begin
        e = mduQ.pop_front();
        chk("mdu_rd", 32'(out_rd), 32'(e.rd));
        chk("mdu_data", out_data, e.data);
      end
    end
  endtask

  function automatic wr_t mk(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

  // Directed sequence covering reset, drain, starvation, full, kill, x0 and mid-run reset.
  initial begin
    reset = 1'b0; pipe_write_enable = 1'b0; pipe_rd = '0; pipe_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0);
    checkOutput();
    chk("rst_we", 32'(out_write_enable), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    chk("rst_stall", 32'(stall_pipe), 32'd0);
    chk("rst_mask", pending_rd_mask, 32'd0);

    $display("[TB] idle drain");
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    mduQ.push_back(mk(5'd5, 32'hDEADBEEF));
    checkOutput();
    chk("t1_ready", 32'(mdu_ready), 32'd1);
    chk("t1_no_bypass", 32'(out_write_enable), 32'd0);
    chk("t1_mask_t", pending_rd_mask, 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("t1_we_t1", 32'(out_write_enable), 32'd1);
    chk("t1_mask_t1", pending_rd_mask, 32'h0000_0020);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("t1_mask_t2", pending_rd_mask, 32'd0);
    chk("t1_we_t2", 32'(out_write_enable), 32'd0);

    $display("[TB] starvation");
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h100, 1'b1, 5'd7, 32'h7777, 1'b1);
    mduQ.push_back(mk(5'd7, 32'h7777));
    checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b0, 5'd0, 32'h0, 1'b1);
      checkOutput();
      chk("sv_no_stall", 32'(stall_pipe), 32'd0);
      chk("sv_mask7", 32'(pending_rd_mask[7]), 32'd1);
    end
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("sv_stall", 32'(stall_pipe), 32'd1);
    chk("sv_head_rd", 32'(out_rd), 32'd7);
    chk("sv_head_we", 32'(out_write_enable), 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h300, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput();
    chk("sv_stall_once", 32'(stall_pipe), 32'd0);
    chk("sv_mask_clr", pending_rd_mask, 32'd0);

    $display("[TB] full buffer");
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h401, 1'b1, 5'd11, 32'hAAAA, 1'b1);
    mduQ.push_back(mk(5'd11, 32'hAAAA));
    checkOutput();
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h402, 1'b1, 5'd12, 32'hBBBB, 1'b1);
    mduQ.push_back(mk(5'd12, 32'hBBBB));
    checkOutput();
    chk("fu_ready_one", 32'(mdu_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hCCCC, 1'b0);
    checkOutput();
    chk("fu_ready_full", 32'(mdu_ready), 32'd0);
    chk("fu_pop_we", 32'(out_write_enable), 32'd1);
    chk("fu_mask", pending_rd_mask, 32'h0000_1800);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("fu_ready_back", 32'(mdu_ready), 32'd1);
    chk("fu_mask_after", pending_rd_mask, 32'h0000_1000);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("fu_no_13", 32'(out_write_enable), 32'd0);

    $display("[TB] WAW kill");
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h501, 1'b1, 5'd9, 32'h9999, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0, 1'b1);
    checkOutput();
    chk("k_mask9_set", 32'(pending_rd_mask[9]), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("k_mask9_clr", 32'(pending_rd_mask[9]), 32'd0);
    chk("k_pop_no_we", 32'(out_write_enable), 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'h2, 1'b1, 5'd9, 32'h3, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("k_push_kill_mask", pending_rd_mask, 32'd0);
    chk("k_push_kill_we", 32'(out_write_enable), 32'd0);

    $display("[TB] x0 destinations");
    applyStimulus(1'b1, 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 1'b0);
    checkOutput();
    chk("z_ready", 32'(mdu_ready), 32'd1);
    chk("z_we", 32'(out_write_enable), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("z_mask", pending_rd_mask, 32'd0);
    chk("z_we_next", 32'(out_write_enable), 32'd0);

    $display("[TB] mid-run reset");
    applyStimulus(1'b1, 1'b1, 5'd1, 32'h601, 1'b1, 5'd20, 32'h2020, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 5'd2, 32'h602, 1'b1, 5'd21, 32'h2121, 1'b1);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h603, 1'b1, 5'd22, 32'h2222, 1'b0);
    checkOutput();
    chk("mr_we", 32'(out_write_enable), 32'd0);
    chk("mr_ready", 32'(mdu_ready), 32'd0);
    chk("mr_mask_before", pending_rd_mask, 32'h0030_0000);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("mr_mask", pending_rd_mask, 32'd0);
    chk("mr_stall", 32'(stall_pipe), 32'd0);
    chk("mr_ready_back", 32'(mdu_ready), 32'd1);
    chk("mr_no_we", 32'(out_write_enable), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    checkOutput();
    chk("mr_no_we2", 32'(out_write_enable), 32'd0);

    chk("mdu_queue_drained", 32'(mduQ.size()), 32'd0);
    chk("pipe_queue_drained", 32'(pipeQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
